// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scans NDIG digits through one shared BCD-to-7-segment decoder.
// Latency: bcd_out/dig_en registered (1 cycle after state decision); seg_out/frame_done combinational on registered state.
// Backpressure: load_ready drops while a word is pending; it is promoted to active only at scan start or frame boundary.
// Optional feature: define SEG_SCAN_LZB_EN for leading-zero blanking.
module seg_scan_ctrl #(
  parameter int NDIG      = 4,
  parameter int PRESCALE  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load_valid,
  input  logic [4*NDIG-1:0] load_data,
  output logic              load_ready,
  output logic [3:0]        bcd_out,
  input  logic [6:0]        seg_in,
  output logic [6:0]        seg_out,
  output logic [NDIG-1:0]   dig_en,
  output logic              frame_done
);

  localparam int CMAX = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
  localparam int CW   = $clog2(CMAX);
  localparam int IW   = $clog2(NDIG);
  localparam logic [CW-1:0] SHOW_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  typedef enum logic [1:0] {ST_OFF, ST_SHOW, ST_GAP} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [IW-1:0]     idx, idx_nxt, idx_inc;
  logic              start, boundary, copy;
  logic [4*NDIG-1:0] active, pending, active_nxt;
  logic              pending_full;
  logic [NDIG-1:0]   dig_en_nxt;
  logic [3:0]        bcd_nxt;
  logic              lz_blank;

  // State, slot counter and digit index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_OFF;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state: slot timing, digit advance, scan start and frame boundary detection.
  // The index advances when a digit's SHOW ends, so during GAP it already names the next digit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    start     = 1'b0;
    boundary  = 1'b0;
    idx_inc   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    case (state)
      ST_OFF: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (en) begin
          state_nxt = ST_SHOW;
          start     = 1'b1;
        end
      end
      ST_SHOW: begin
        if (!en) begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else if (cnt == SHOW_LAST) begin
          cnt_nxt = '0;
          idx_nxt = idx_inc;
          if (BLANK_CYC == 0) begin
            boundary = (idx == IDX_LAST);
          end else begin
            state_nxt = ST_GAP;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_GAP: begin
        if (!en) begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else if (cnt == GAP_LAST) begin
          state_nxt = ST_SHOW;
          cnt_nxt   = '0;
          boundary  = (idx == '0);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_OFF;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // Pending word is promoted only at scan start or frame boundary, so a frame never tears
  always_comb begin
    copy       = pending_full & (start | boundary);
    active_nxt = copy ? pending : active;
  end

  // Double buffer: pending register fills on handshake, empties on promotion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else begin
      active <= active_nxt;
      if (copy) begin
        pending_full <= 1'b0;
      end else if (load_valid && load_ready) begin
        pending      <= load_data;
        pending_full <= 1'b1;
      end
    end
  end

  // Outputs: next-cycle digit enable and nibble, plus pin gating of the decoder result
  always_comb begin
    dig_en_nxt = (state_nxt == ST_SHOW) ? (NDIG'(1) << idx_nxt) : '0;
    bcd_nxt    = active_nxt[idx_nxt*4 +: 4];
`ifdef SEG_SCAN_LZB_EN
    lz_blank   = (idx != '0) && ((active >> {idx, 2'b00}) == '0);
`else
    lz_blank   = 1'b0;
`endif
    seg_out    = ((state == ST_SHOW) && (bcd_out <= 4'd9) && !lz_blank) ? seg_in : '0;
    frame_done = boundary;
    load_ready = ~pending_full;
  end

  // Registered pin-facing outputs so digit enables never glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out <= '0;
      dig_en  <= '0;
    end else begin
      bcd_out <= bcd_nxt;
      dig_en  <= dig_en_nxt;
    end
  end

endmodule
